// File: rtl/jam_cost_table_if.sv
// Loader stream + solver lookup bundle for jam_cost_table.
// master = host/JAM side, slave = the cost table block.
interface jam_cost_table_if #(
  parameter int N_WORKER = 8,
  parameter int N_JOB    = 8,
  parameter int COST_W   = 7
);
  logic                        In_Valid;
  logic                        In_Ready;
  logic [COST_W-1:0]           In_Data;
  logic                        In_Last;
  logic                        Reload;
  logic [$clog2(N_WORKER)-1:0] W;
  logic [$clog2(N_JOB)-1:0]    J;
  logic [COST_W-1:0]           Cost;
  logic                        Table_Ready;
  logic                        Load_Err;
  logic                        Jam_Rst;

  modport master (
    output In_Valid, In_Data, In_Last, Reload, W, J,
    input  In_Ready, Cost, Table_Ready, Load_Err, Jam_Rst
  );

  modport slave (
    input  In_Valid, In_Data, In_Last, Reload, W, J,
    output In_Ready, Cost, Table_Ready, Load_Err, Jam_Rst
  );
endinterface

// File: rtl/jam_cost_table.sv
// Worker/job cost table for the JAM solver: loads a framed cost stream, serves lookups,
// holds JAM in reset until the table is valid. Define CHECKSUM_EN for a trailing checksum word.
module jam_cost_table #(
  parameter int N_WORKER = 8,
  parameter int N_JOB    = 8,
  parameter int COST_W   = 7
) (
  input  logic           CLK,
  input  logic           RST,
  jam_cost_table_if.slave bus
);
  localparam int DEPTH = N_WORKER * N_JOB;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {LOAD, READY, ERR} state_t;

  state_t            state;
  logic [AW-1:0]     wr_idx;
  logic              in_ready, table_ready, load_err, jam_rst;
  logic [COST_W-1:0] mem [DEPTH];
  logic [AW-1:0]     rd_idx;
  logic              xfer, store, done, bad;

  // in_ready is only ever high in LOAD, so a handshake implies LOAD
  assign xfer = bus.In_Valid && in_ready;

`ifdef CHECKSUM_EN
  logic              csum_phase;
  logic [COST_W-1:0] sum;

  always_comb begin
    store = !csum_phase;
    done  = csum_phase && bus.In_Last && (bus.In_Data == sum);
    bad   = csum_phase ? !done : bus.In_Last;
  end

  // running sum wraps naturally at COST_W bits
  always_ff @(posedge CLK) begin
    if (RST || bus.Reload) begin
      csum_phase <= 1'b0;
      sum        <= '0;
    end else if (xfer && store) begin
      sum <= sum + bus.In_Data;
      if (wr_idx == LAST_IDX) csum_phase <= 1'b1;
    end
  end
`else
  always_comb begin
    store = 1'b1;
    done  = (wr_idx == LAST_IDX) && bus.In_Last;
    bad   = (wr_idx == LAST_IDX) != bus.In_Last;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= LOAD;
      wr_idx      <= '0;
      in_ready    <= 1'b0;
      table_ready <= 1'b0;
      load_err    <= 1'b0;
      jam_rst     <= 1'b1;
    end else if (bus.Reload) begin
      state       <= LOAD;
      wr_idx      <= '0;
      in_ready    <= 1'b1;
      table_ready <= 1'b0;
      load_err    <= 1'b0;
      jam_rst     <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          in_ready <= 1'b1;
          if (xfer) begin
            if (done) begin
              state       <= READY;
              table_ready <= 1'b1;
              in_ready    <= 1'b0;
            end else if (bad) begin
              state    <= ERR;
              load_err <= 1'b1;
              in_ready <= 1'b0;
            end else if (store) begin
              wr_idx <= wr_idx + 1'b1;
            end
          end
        end
        // JAM gets one reset cycle with the table already valid
        READY:   jam_rst <= 1'b0;
        default: ;
      endcase
    end
  end

  // table contents survive reset
  always_ff @(posedge CLK) begin
    if (!RST && !bus.Reload && xfer && store) mem[wr_idx] <= bus.In_Data;
  end

  assign rd_idx          = AW'({bus.W, bus.J});
  assign bus.Cost        = table_ready ? mem[rd_idx] : '0;
  assign bus.In_Ready    = in_ready;
  assign bus.Table_Ready = table_ready;
  assign bus.Load_Err    = load_err;
  assign bus.Jam_Rst     = jam_rst;
endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream neighbour of the JAM assignment solver: owns the 8x8 worker/job cost table the solver reads through its W/J/Cost lookup.
- Loads 64 7-bit costs from a valid/ready byte stream, then serves combinational lookups.
- Holds the solver in reset until a complete, well-formed table is resident.
- Sits between the test/host loader and JAM; JAM's RST is driven from Jam_Rst.

Parameters:
- N_WORKER, 8, table rows (workers); index width 3.
- N_JOB, 8, table columns (jobs); index width 3.
- COST_W, 7, cost word width.

Ports:
- CLK  input  1  system clock, all state on posedge.
- RST  input  1  synchronous active-high reset.
- In_Valid  input  1  loader word valid.
- In_Ready  output  1  block accepts a word this cycle.
- In_Data  input  7  cost word; row-major order, index = W*8 + J.
- In_Last  input  1  marks final word of a load frame.
- Reload  input  1  one-cycle request to discard the table and accept a new frame.
- W  input  3  lookup worker index (from JAM).
- J  input  3  lookup job index (from JAM).
- Cost  output  7  table[W][J]; combinational.
- Table_Ready  output  1  table complete and valid.
- Load_Err  output  1  sticky framing or checksum error.
- Jam_Rst  output  1  reset to downstream solver; registered.

Behaviour:
- One clock (CLK). Reset is synchronous and active-high (RST).
- States: LOAD, READY, ERR. RST enters LOAD.
- Reset values: In_Ready=0 in the reset cycle, then 1 in LOAD. Table_Ready=0, Load_Err=0, Jam_Rst=1, word counter wr_idx=0. Table contents are not cleared.
- Handshake: a word transfers on a cycle with In_Valid && In_Ready.
  - In_Ready=1 only in LOAD.
  - In_Data and In_Last are ignored when no transfer occurs.
- LOAD:
  - Each transfer writes table[wr_idx] and increments the 6-bit wr_idx.
  - Transfer with wr_idx==63 and In_Last=1 -> READY next cycle.
  - In_Last=1 with wr_idx<63 -> ERR (early last).
  - wr_idx==63 with In_Last=0 -> ERR (missing last); wr_idx does not wrap into a valid frame.
- READY:
  - Table_Ready=1, In_Ready=0.
  - Jam_Rst deasserts one cycle after Table_Ready rises, so JAM sees at least one reset cycle with a valid table.
- ERR:
  - Load_Err=1, Table_Ready=0, Jam_Rst=1, In_Ready=0.
  - Left only by RST or Reload.
- Reload (in READY or ERR):
  - -> LOAD next cycle; wr_idx=0, Table_Ready=0, Load_Err=0.
  - Jam_Rst=1 from the next cycle.
  - Reload in LOAD restarts the frame (wr_idx=0); any same-cycle transfer is discarded.
- Cost = table[{W,J}] when Table_Ready=1, else 0.
  - No latency, so JAM may change W/J every cycle.
  - Lookup during LOAD returns 0 even for already-written entries.
- RST overrides all, including a transfer or Reload in the same cycle.

Optional Feature:
- Macro CHECKSUM_EN.
- Defined:
  - Frame is 65 words. Word 64 is a checksum equal to the sum of the 64 costs modulo 128.
  - In_Last is expected on word 64, not word 63; a 7-bit running sum is kept.
  - Mismatch -> ERR. Match -> READY.
  - The checksum word is not stored.
- Undefined: 64-word frame as above; no adder present.

Test Plan:
- Reset, stream costs table[i]=i mod 100 for i=0..63 with In_Last on i=63, In_Valid continuous -> Table_Ready=1 one cycle after last transfer; Jam_Rst falls one cycle later; W=3,J=5 -> Cost=29; W=7,J=7 -> Cost=63.
- Stream with In_Valid toggling every other cycle -> wr_idx advances only on handshakes; final table identical to the continuous case.
- In_Last asserted on word 10 -> Load_Err=1 next cycle, Table_Ready=0, Cost=0, Jam_Rst stays 1; then Reload + valid frame -> Load_Err=0, Table_Ready=1.
- 64 words with In_Last=0 throughout -> ERR after word 63; Reload mid-LOAD at word 20 then a full frame -> table holds only the new frame.
- After READY, pulse Reload -> Table_Ready=0 and Jam_Rst=1 next cycle; RST asserted same cycle as a transfer -> transfer dropped, wr_idx=0.
- CHECKSUM_EN: all costs 1, checksum word 64 -> READY; checksum word 63 -> Load_Err=1.
